// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
//   Multi-cycle adder/subtractor. WIDTH-bit operands are processed DIGIT bits
//   per clock, least-significant digit first, with a carry flop linking
//   successive digits. Subtraction uses the borrow form a - b - Cin, computed
//   as a + ~b + (1 - Cin).
//
//   Handshake: start is accepted whenever busy==0 (IDLE or DONE). busy is high
//   for STEPS = WIDTH/DIGIT clocks, then done pulses for one cycle, with
//   out/Cout (and ovf) valid from that cycle and held until the next
//   completion.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits added per clock; WIDTH must be a multiple of DIGIT
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (aborts any operation)
//   start  in   request, sampled only while busy==0
//   a, b   in   operands, captured on an accepted start
//   Cin    in   carry-in (add) / extra borrow (sub), captured on start
//   sub    in   1: out = a - b - Cin, 0: out = a + b + Cin
//   busy   out  high while a calculation is in progress
//   done   out  one-cycle completion pulse
//   out    out  result, modulo 2^WIDTH
//   Cout   out  carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//   ovf    out  signed overflow; exists only when SERADD_OVF_EN is defined
//
// Configuration macro
//   SERADD_OVF_EN  adds the ovf port and its overflow logic
// -----------------------------------------------------------------------------
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             Cout
`ifdef SERADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               cout_q, cout_d;

  // One digit of the ripple: {carry, sum} of the low DIGIT bits plus carry.
  logic [DIGIT:0]         dsum;
  // Result register with the new digit prepended; the upper WIDTH bits are
  // the register after shifting the digit in at the MSB end. Written this way
  // so DIGIT == WIDTH needs no special case.
  logic [WIDTH+DIGIT-1:0] res_cat;

  assign dsum    = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_q};
  assign res_cat = {dsum[DIGIT-1:0], res_q};

`ifdef SERADD_OVF_EN
  logic ovf_q, ovf_d;
  // Carry into the top bit of the current digit, recovered from a ^ b ^ sum.
  // Only meaningful on the final digit, where that bit is bit WIDTH-1.
  logic msb_cin;
  assign msb_cin = opa_q[DIGIT-1] ^ opb_q[DIGIT-1] ^ dsum[DIGIT-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
`ifdef SERADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    cout_d  = cout_q;
`ifdef SERADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      // DONE accepts a new start exactly like IDLE (back-to-back operation).
      S_IDLE, S_DONE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          // Subtraction is a + ~b + 1 - Cin, so the initial carry is Cin ^ sub.
          carry_d = Cin ^ sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        res_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          out_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
          cout_d  = dsum[DIGIT];
`ifdef SERADD_OVF_EN
          ovf_d   = dsum[DIGIT] ^ msb_cin;
`endif
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign out  = out_q;
  assign Cout = cout_q;
`ifdef SERADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
//   Three instances of serial_add_sub (WIDTH=8; DIGIT = 1, 4, 8) driven from
//   one stimulus process. When a start is accepted, the expected completion
//   (cycle, result, carry, overflow) is computed with plain integer arithmetic
//   and queued; a monitor on the falling edge compares busy/done/out/Cout
//   (and ovf when SERADD_OVF_EN is defined) against the queue every cycle.
// -----------------------------------------------------------------------------
module tb_serial_add_sub;

  localparam int W  = 8;
  localparam int NI = 3;

  typedef struct {
    int         inst;
    int         due;
    logic [W-1:0] o;
    logic       c;
    logic       v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_s [NI];
  logic [W-1:0] a_s     [NI];
  logic [W-1:0] b_s     [NI];
  logic         cin_s   [NI];
  logic         sub_s   [NI];
  logic         busy_s  [NI];
  logic         done_s  [NI];
  logic [W-1:0] out_s   [NI];
  logic         cout_s  [NI];
`ifdef SERADD_OVF_EN
  logic         ovf_s   [NI];
`endif

  for (genvar gi = 0; gi < NI; gi++) begin : gen_dut
    localparam int DIG = (gi == 0) ? 1 : ((gi == 1) ? 4 : 8);
    serial_add_sub #(.WIDTH(W), .DIGIT(DIG)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_s[gi]),
      .a     (a_s[gi]),
      .b     (b_s[gi]),
      .Cin   (cin_s[gi]),
      .sub   (sub_s[gi]),
      .busy  (busy_s[gi]),
      .done  (done_s[gi]),
      .out   (out_s[gi]),
      .Cout  (cout_s[gi])
`ifdef SERADD_OVF_EN
      ,
      .ovf   (ovf_s[gi])
`endif
    );
  end

  exp_t         scb [$];
  int           cyc = 0;
  int           free_e   [NI];
  logic [W-1:0] hold_o   [NI];
  logic         hold_c   [NI];
  logic         hold_v   [NI];
  int           checks = 0;
  int           errors = 0;

  function automatic int steps(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 2 : 1);
  endfunction

  // Reference: integer arithmetic straight from the add/sub definitions.
  function automatic exp_t model(input int i, input int due, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic ci, input logic sb_);
    exp_t e;
    int ux, uy, uc, sx, sy, r, u;
    ux = int'(x);
    uy = int'(y);
    uc = int'(ci);
    sx = $signed(x);
    sy = $signed(y);
    if (!sb_) begin
      u   = ux + uy + uc;
      e.o = u[W-1:0];
      e.c = (u >= 256);
      r   = sx + sy + uc;
    end else begin
      u   = ux - uy - uc;
      e.o = u[W-1:0];
      e.c = (ux >= uy + uc);
      r   = sx - sy - uc;
    end
    e.v    = (r > 127) || (r < -128);
    e.inst = i;
    e.due  = due;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: record which starts the DUTs see at this edge, then step off it.
  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (rst_n && start_s[i] && cyc >= free_e[i]) begin
        scb.push_back(model(i, cyc + steps(i), a_s[i], b_s[i], cin_s[i], sub_s[i]));
        free_e[i] = cyc + steps(i) + 1;
      end
    end
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic sb_);
    a_s[i]   = x;
    b_s[i]   = y;
    cin_s[i] = ci;
    sub_s[i] = sb_;
  endtask

  task automatic run_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sb_);
    set_ops(i, x, y, ci, sb_);
    start_s[i] = 1'b1;
    tick();
    start_s[i] = 1'b0;
    repeat (steps(i) + 1) tick();
  endtask

  task automatic clear_model();
    scb.delete();
    for (int i = 0; i < NI; i++) begin
      free_e[i] = 0;
      hold_o[i] = '0;
      hold_c[i] = 1'b0;
      hold_v[i] = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_busy[%0d]", tag, i), 32'(busy_s[i]), 32'd0);
      chk($sformatf("%s_done[%0d]", tag, i), 32'(done_s[i]), 32'd0);
      chk($sformatf("%s_out[%0d]",  tag, i), 32'(out_s[i]),  32'd0);
      chk($sformatf("%s_cout[%0d]", tag, i), 32'(cout_s[i]), 32'd0);
`ifdef SERADD_OVF_EN
      chk($sformatf("%s_ovf[%0d]",  tag, i), 32'(ovf_s[i]),  32'd0);
`endif
    end
  endtask

  // Monitor: every falling edge, compare each instance against the queue.
  always @(negedge clk) begin
    int   idx;
    logic eb, ed;
    for (int k = 0; k < NI; k++) begin
      idx = -1;
      for (int j = 0; j < scb.size(); j++)
        if (idx < 0 && scb[j].inst == k) idx = j;
      eb = (idx >= 0) && (scb[idx].due > cyc);
      ed = (idx >= 0) && (scb[idx].due == cyc);
      chk($sformatf("busy[%0d]@%0d", k, cyc), 32'(busy_s[k]), 32'(eb));
      chk($sformatf("done[%0d]@%0d", k, cyc), 32'(done_s[k]), 32'(ed));
      if (ed) begin
        hold_o[k] = scb[idx].o;
        hold_c[k] = scb[idx].c;
        hold_v[k] = scb[idx].v;
        scb.delete(idx);
      end
      chk($sformatf("out[%0d]@%0d", k, cyc),  32'(out_s[k]),  32'(hold_o[k]));
      chk($sformatf("cout[%0d]@%0d", k, cyc), 32'(cout_s[k]), 32'(hold_c[k]));
`ifdef SERADD_OVF_EN
      chk($sformatf("ovf[%0d]@%0d", k, cyc),  32'(ovf_s[k]),  32'(hold_v[k]));
`endif
    end
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0]   kk;
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start_s[i] = 1'b0;
      set_ops(i, '0, '0, 1'b0, 1'b0);
    end
    clear_model();
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("rst0");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed results with constants worked out by hand.
    run_op(0, 8'h3C, 8'h0F, 1'b0, 1'b0);
    chk("dir_3C+0F_out", 32'(out_s[0]), 32'h4B);
    chk("dir_3C+0F_cout", 32'(cout_s[0]), 32'd0);
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    chk("dir_FF+01_out", 32'(out_s[0]), 32'h00);
    chk("dir_FF+01_cout", 32'(cout_s[0]), 32'd1);
`ifdef SERADD_OVF_EN
    chk("dir_FF+01_ovf", 32'(ovf_s[0]), 32'd0);
`endif
    run_op(0, 8'h05, 8'h07, 1'b0, 1'b1);
    chk("dir_05-07_out", 32'(out_s[0]), 32'hFE);
    chk("dir_05-07_cout", 32'(cout_s[0]), 32'd0);
    run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0);
    chk("dir_7F+01_out", 32'(out_s[0]), 32'h80);
`ifdef SERADD_OVF_EN
    chk("dir_7F+01_ovf", 32'(ovf_s[0]), 32'd1);
`endif
    run_op(0, 8'h05, 8'h07, 1'b1, 1'b1);
    chk("dir_05-07-1_out", 32'(out_s[0]), 32'hFD);

    // start re-pulsed with new operands during RUN is ignored.
    set_ops(0, 8'h12, 8'h34, 1'b0, 1'b0);
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    tick();
    tick();
    set_ops(0, 8'hFF, 8'hFF, 1'b1, 1'b1);
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    repeat (6) tick();
    chk("ignored_start_out", 32'(out_s[0]), 32'h46);

    // start held high: back-to-back operations, operands changing every cycle.
    start_s[0] = 1'b1;
    for (int n = 0; n < 27; n++) begin
      set_ops(0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    start_s[0] = 1'b0;
    repeat (10) tick();

    // Asynchronous reset in the middle of RUN aborts the operation.
    run_op(0, 8'hA5, 8'h5A, 1'b1, 1'b0);
    set_ops(0, 8'h33, 8'h11, 1'b0, 1'b0);
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    repeat (4) tick();
    #1 rst_n = 1'b0;
    clear_model();
    #1 check_reset_outputs("rst_mid");
    tick();
    rst_n = 1'b1;
    repeat (12) tick();

    // Cin/sub/MSB corner combinations on every digit size.
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 8; k++) begin
        kk = 4'(k);
        ra = {kk[2], 7'($urandom)};
        rb = {kk[2], 7'($urandom)};
        run_op(i, ra, rb, kk[0], kk[1]);
      end
      run_op(i, 8'h80, 8'h7F, 1'b1, 1'b1);
      run_op(i, 8'h00, 8'hFF, 1'b1, 1'b0);
    end

    // Random operations with random gaps; short gaps land starts on busy DUTs.
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 25; n++) begin
        set_ops(i, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        start_s[i] = 1'b1;
        tick();
        start_s[i] = 1'b0;
        repeat ($urandom_range(steps(i) + 2, 0)) tick();
      end
      repeat (steps(i) + 2) tick();
    end

    repeat (4) tick();
    chk("scoreboard_drained", 32'(scb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
